// File: rtl/onchip_ram_pkg.sv
// Package: onchip_ram_pkg
// Shared constants and types for the dual-port arbitrated on-chip RAM.
//   DATA_W_DEF / ADDR_W_DEF : default word width / word-address width
//   RD_LAT                  : read latency in cycles (accept edge -> readdatavalid)
//   port_id_t               : identifies which slave port owns a grant / read tag
// Build option: ONCHIP_RAM_OUTREG_EN adds an output register (RD_LAT = 2).
package onchip_ram_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 14;

`ifdef ONCHIP_RAM_OUTREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  typedef enum logic {
    P_S1 = 1'b0,
    P_S2 = 1'b1
  } port_id_t;

endpackage

// File: rtl/onchip_ram_arb2_if.sv
// Interface: onchip_ram_arb2_if
// One Avalon-MM slave port bundle (address/read/write/byteenable/writedata
// towards the RAM; waitrequest/readdata/readdatavalid back to the master).
//   master modport : seen from the bus master
//   slave  modport : seen from the RAM
interface onchip_ram_arb2_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/onchip_ram_core.sv
// Module: onchip_ram_core
// Inferred byte-enabled single-port RAM with registered read data.
//   clk     : clock
//   i_ce    : clock enable for the whole block (0 = freeze, no access)
//   i_en    : access strobe for this cycle
//   i_we    : 1 = write, 0 = read
//   i_addr  : word address
//   i_be    : byte lanes to update on a write
//   i_wdata : write data
//   o_q     : read data, one cycle after the read (two with the output register)
// Build option: ONCHIP_RAM_OUTREG_EN inserts a second read-data register.
// Contents are never reset.
module onchip_ram_core #(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 14,
  parameter string INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  i_ce,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_W/8-1:0]   i_be,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_q
);

  logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
  logic [DATA_W-1:0] r_q;

  // Array access: byte-lane write or registered read, never both in one cycle.
  always_ff @(posedge clk) begin
    if (i_ce && i_en) begin
      if (i_we) begin
        for (int b = 0; b < DATA_W / 8; b++) begin
          if (i_be[b]) begin
            r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
          end
        end
      end else begin
        r_q <= r_mem[i_addr];
      end
    end
  end

`ifdef ONCHIP_RAM_OUTREG_EN
  logic [DATA_W-1:0] r_q2;

  // Second read-data stage; advances with the rest of the block.
  always_ff @(posedge clk) begin
    if (i_ce) begin
      r_q2 <= r_q;
    end
  end

  assign o_q = r_q2;
`else
  assign o_q = r_q;
`endif

endmodule

// File: rtl/onchip_ram_arb2.sv
// Module: onchip_ram_arb2
// On-chip data RAM shared by two Avalon-MM slave ports through a
// round-robin arbiter (one access per cycle, pipelined reads).
//   clk       : single clock domain
//   reset     : asynchronous, active-high
//   clken     : global clock enable, 0 freezes the block
//   reset_req : 1 suspends RAM access (same effect as clken = 0)
//   s1        : slave port for the Nios data master
//   s2        : slave port for the accelerator
// Build option: ONCHIP_RAM_OUTREG_EN -> read latency 2 instead of 1.
module onchip_ram_arb2
  import onchip_ram_pkg::*;
#(
  parameter int    DATA_W    = DATA_W_DEF,
  parameter int    ADDR_W    = ADDR_W_DEF,
  parameter string INIT_FILE = "onchip_ram.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,
  onchip_ram_arb2_if.slave        s1,
  onchip_ram_arb2_if.slave        s2
);

  localparam int BE_W = DATA_W / 8;

  logic              w_active;
  logic              w_req1;
  logic              w_req2;
  logic              w_gnt1;
  logic              w_gnt2;
  port_id_t          w_sel;
  logic              w_en;
  logic              w_we;
  logic              w_rd_acc;
  logic [ADDR_W-1:0] w_addr;
  logic [BE_W-1:0]   w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_q;

  port_id_t          r_rr;
  logic [RD_LAT-1:0] r_vld;
  logic [RD_LAT-1:0] r_tag;
  logic [DATA_W-1:0] r_hold1;
  logic [DATA_W-1:0] r_hold2;

  assign w_active = clken & ~reset_req;
  assign w_req1   = s1.read | s1.write;
  assign w_req2   = s2.read | s2.write;

  // Round-robin grant; nothing is granted while the block is frozen.
  always_comb begin
    w_gnt1 = 1'b0;
    w_gnt2 = 1'b0;
    if (w_active) begin
      if (w_req1 && w_req2) begin
        if (r_rr == P_S1) begin
          w_gnt1 = 1'b1;
        end else begin
          w_gnt2 = 1'b1;
        end
      end else if (w_req1) begin
        w_gnt1 = 1'b1;
      end else if (w_req2) begin
        w_gnt2 = 1'b1;
      end else begin
        w_gnt1 = 1'b0;
        w_gnt2 = 1'b0;
      end
    end else begin
      w_gnt1 = 1'b0;
      w_gnt2 = 1'b0;
    end
  end

  // A frozen block stalls everyone; otherwise only a losing requester waits.
  assign s1.waitrequest = ~w_active | (w_req1 & ~w_gnt1);
  assign s2.waitrequest = ~w_active | (w_req2 & ~w_gnt2);

  // Route the winning port onto the RAM; write takes priority over read.
  always_comb begin
    w_sel   = P_S1;
    w_addr  = s1.address;
    w_we    = s1.write;
    w_be    = s1.byteenable;
    w_wdata = s1.writedata;
    if (w_gnt2) begin
      w_sel   = P_S2;
      w_addr  = s2.address;
      w_we    = s2.write;
      w_be    = s2.byteenable;
      w_wdata = s2.writedata;
    end else begin
      w_sel   = P_S1;
    end
  end

  assign w_en     = w_gnt1 | w_gnt2;
  assign w_rd_acc = w_en & ~w_we;

  // Round-robin pointer: under contention hand the next turn to the loser.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr <= P_S1;
    end else if (w_active && w_req1 && w_req2) begin
      r_rr <= w_gnt1 ? P_S2 : P_S1;
    end
  end

  // Read-tag shift register: marks which port owns data leaving the RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
      r_tag <= '0;
    end else if (w_active) begin
      r_vld[0] <= w_rd_acc;
      r_tag[0] <= w_sel;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // Valid is gated by w_active so a frozen cycle cannot repeat the pulse.
  assign s1.readdatavalid = w_active & r_vld[RD_LAT-1] & (r_tag[RD_LAT-1] == P_S1);
  assign s2.readdatavalid = w_active & r_vld[RD_LAT-1] & (r_tag[RD_LAT-1] == P_S2);

  // Capture each port's last returned word so readdata holds between pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold1 <= '0;
      r_hold2 <= '0;
    end else begin
      if (s1.readdatavalid) begin
        r_hold1 <= w_q;
      end
      if (s2.readdatavalid) begin
        r_hold2 <= w_q;
      end
    end
  end

  assign s1.readdata = s1.readdatavalid ? w_q : r_hold1;
  assign s2.readdata = s2.readdatavalid ? w_q : r_hold2;

  onchip_ram_core #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_core (
    .clk     (clk),
    .i_ce    (w_active),
    .i_en    (w_en),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_be    (w_be),
    .i_wdata (w_wdata),
    .o_q     (w_q)
  );

endmodule

// File: tb/tb_onchip_ram_arb2.sv
// Testbench: tb_onchip_ram_arb2
// Directed table of per-cycle vectors plus hand-written sequences for
// contention, clock-enable freeze and reset during an in-flight read.
// Expected read returns are placed RD_LAT rows after the accepting row.
module tb_onchip_ram_arb2;
  import onchip_ram_pkg::*;

  localparam int NROW = 24;

  logic clk = 1'b0;
  logic reset;
  logic clken;
  logic reset_req;

  int n_run  = 0;
  int n_fail = 0;

  onchip_ram_arb2_if #(.DATA_W(32), .ADDR_W(14)) s1_if ();
  onchip_ram_arb2_if #(.DATA_W(32), .ADDR_W(14)) s2_if ();

  onchip_ram_arb2 #(
    .DATA_W    (32),
    .ADDR_W    (14),
    .INIT_FILE ("")
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clken     (clken),
    .reset_req (reset_req),
    .s1        (s1_if),
    .s2        (s2_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rq;
    logic        r1, w1;
    logic [3:0]  be1;
    logic [13:0] a1;
    logic [31:0] d1;
    logic        r2, w2;
    logic [3:0]  be2;
    logic [13:0] a2;
    logic [31:0] d2;
    logic        ew1, ew2;
    logic        ev1, ev2;
    logic [31:0] ed1, ed2;
  } vec_t;

  vec_t tbl [NROW];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic in1(input int r, input logic rd, input logic wr, input logic [3:0] be,
                     input logic [13:0] a, input logic [31:0] d);
    tbl[r].r1 = rd; tbl[r].w1 = wr; tbl[r].be1 = be; tbl[r].a1 = a; tbl[r].d1 = d;
  endtask

  task automatic in2(input int r, input logic rd, input logic wr, input logic [3:0] be,
                     input logic [13:0] a, input logic [31:0] d);
    tbl[r].r2 = rd; tbl[r].w2 = wr; tbl[r].be2 = be; tbl[r].a2 = a; tbl[r].d2 = d;
  endtask

  task automatic ew(input int r, input logic e1, input logic e2);
    tbl[r].ew1 = e1; tbl[r].ew2 = e2;
  endtask

  // Expected return of a read accepted in row r.
  task automatic ev(input int r, input int port, input logic [31:0] d);
    if (port == 1) begin
      tbl[r + RD_LAT].ev1 = 1'b1; tbl[r + RD_LAT].ed1 = d;
    end else begin
      tbl[r + RD_LAT].ev2 = 1'b1; tbl[r + RD_LAT].ed2 = d;
    end
  endtask

  task automatic idle();
    s1_if.read = 1'b0; s1_if.write = 1'b0; s1_if.byteenable = 4'h0;
    s1_if.address = 14'h0; s1_if.writedata = 32'h0;
    s2_if.read = 1'b0; s2_if.write = 1'b0; s2_if.byteenable = 4'h0;
    s2_if.address = 14'h0; s2_if.writedata = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle();
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [31:0] last1;
  logic [31:0] last2;

  initial begin
    reset = 1'b1;
    clken = 1'b1;
    reset_req = 1'b0;
    idle();

    // ---------------- fill the vector table ----------------
    for (int i = 0; i < NROW; i++) tbl[i] = '{default: '0};
    in1(1, 1'b0, 1'b1, 4'hF, 14'h10, 32'hDEADBEEF);
    in1(2, 1'b1, 1'b0, 4'h0, 14'h10, 32'h0);           ev(2, 1, 32'hDEADBEEF);
    in1(4, 1'b0, 1'b1, 4'h2, 14'h10, 32'h0000AA00);
    in1(5, 1'b1, 1'b0, 4'h0, 14'h10, 32'h0);           ev(5, 1, 32'hDEADAAEF);
    in1(6, 1'b0, 1'b1, 4'hF, 14'h21, 32'h55AA55AA);
    in2(6, 1'b0, 1'b1, 4'hF, 14'h20, 32'h12345678);    ew(6, 1'b0, 1'b1);
    in1(7, 1'b1, 1'b0, 4'h0, 14'h21, 32'h0);
    in2(7, 1'b0, 1'b1, 4'hF, 14'h20, 32'h12345678);    ew(7, 1'b1, 1'b0);
    in1(8, 1'b1, 1'b0, 4'h0, 14'h21, 32'h0);
    in2(8, 1'b1, 1'b0, 4'h0, 14'h20, 32'h0);           ew(8, 1'b0, 1'b1); ev(8, 1, 32'h55AA55AA);
    in1(9, 1'b1, 1'b0, 4'h0, 14'h10, 32'h0);
    in2(9, 1'b1, 1'b0, 4'h0, 14'h20, 32'h0);           ew(9, 1'b1, 1'b0); ev(9, 2, 32'h12345678);
    in1(10, 1'b1, 1'b0, 4'h0, 14'h10, 32'h0);
    in2(10, 1'b1, 1'b0, 4'h0, 14'h21, 32'h0);          ew(10, 1'b0, 1'b1); ev(10, 1, 32'hDEADAAEF);
    in2(11, 1'b1, 1'b0, 4'h0, 14'h21, 32'h0);          ev(11, 2, 32'h55AA55AA);
    in1(12, 1'b1, 1'b1, 4'hF, 14'h30, 32'hCAFEF00D);
    in2(12, 1'b1, 1'b0, 4'h0, 14'h10, 32'h0);          ew(12, 1'b1, 1'b0); ev(12, 2, 32'hDEADAAEF);
    in1(13, 1'b1, 1'b1, 4'hF, 14'h30, 32'hCAFEF00D);
    in1(14, 1'b1, 1'b0, 4'h0, 14'h30, 32'h0);
    in2(14, 1'b0, 1'b1, 4'h0, 14'h10, 32'hFFFFFFFF);   ew(14, 1'b0, 1'b1); ev(14, 1, 32'hCAFEF00D);
    in2(15, 1'b0, 1'b1, 4'h0, 14'h10, 32'hFFFFFFFF);
    in2(16, 1'b1, 1'b0, 4'h0, 14'h10, 32'h0);          ev(16, 2, 32'hDEADAAEF);
    in1(17, 1'b1, 1'b0, 4'h0, 14'h21, 32'h0);          ev(17, 1, 32'h55AA55AA);
    in1(18, 1'b1, 1'b0, 4'h0, 14'h30, 32'h0);          ev(18, 1, 32'hCAFEF00D);
    tbl[22].rq = 1'b1;
    in1(22, 1'b1, 1'b0, 4'h0, 14'h10, 32'h0);          ew(22, 1'b1, 1'b1);

    // ---------------- reset state ----------------
    @(negedge clk);
    #2;
    chk("rst s1_wait",  {31'h0, s1_if.waitrequest},   32'h0);
    chk("rst s2_wait",  {31'h0, s2_if.waitrequest},   32'h0);
    chk("rst s1_rdv",   {31'h0, s1_if.readdatavalid}, 32'h0);
    chk("rst s2_rdv",   {31'h0, s2_if.readdatavalid}, 32'h0);
    chk("rst s1_rdata", s1_if.readdata, 32'h0);
    chk("rst s2_rdata", s2_if.readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // ---------------- table-driven vectors ----------------
    last1 = 32'h0;
    last2 = 32'h0;
    for (int i = 0; i < NROW; i++) begin
      if (i != 0) @(negedge clk);
      reset_req        = tbl[i].rq;
      s1_if.read       = tbl[i].r1;  s1_if.write     = tbl[i].w1;
      s1_if.byteenable = tbl[i].be1; s1_if.address   = tbl[i].a1;
      s1_if.writedata  = tbl[i].d1;
      s2_if.read       = tbl[i].r2;  s2_if.write     = tbl[i].w2;
      s2_if.byteenable = tbl[i].be2; s2_if.address   = tbl[i].a2;
      s2_if.writedata  = tbl[i].d2;
      #2;
      if (tbl[i].ev1) last1 = tbl[i].ed1;
      if (tbl[i].ev2) last2 = tbl[i].ed2;
      chk($sformatf("row%0d s1_wait", i),  {31'h0, s1_if.waitrequest},   {31'h0, tbl[i].ew1});
      chk($sformatf("row%0d s2_wait", i),  {31'h0, s2_if.waitrequest},   {31'h0, tbl[i].ew2});
      chk($sformatf("row%0d s1_rdv", i),   {31'h0, s1_if.readdatavalid}, {31'h0, tbl[i].ev1});
      chk($sformatf("row%0d s2_rdv", i),   {31'h0, s2_if.readdatavalid}, {31'h0, tbl[i].ev2});
      chk($sformatf("row%0d s1_rdata", i), s1_if.readdata, last1);
      chk($sformatf("row%0d s2_rdata", i), s2_if.readdata, last2);
    end
    reset_req = 1'b0;
    idle();

    // ---------------- continuous contention after reset ----------------
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c != 0) @(negedge clk);
      s1_if.read = 1'b1; s1_if.address = 14'h10;
      s2_if.read = 1'b1; s2_if.address = 14'h21;
      #2;
      chk($sformatf("rr c%0d s1_wait", c), {31'h0, s1_if.waitrequest}, (c % 2 == 1) ? 32'h1 : 32'h0);
      chk($sformatf("rr c%0d s2_wait", c), {31'h0, s2_if.waitrequest}, (c % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("rr c%0d s1_rdv", c), {31'h0, s1_if.readdatavalid},
          ((c >= RD_LAT) && ((c - RD_LAT) % 2 == 0)) ? 32'h1 : 32'h0);
      chk($sformatf("rr c%0d s2_rdv", c), {31'h0, s2_if.readdatavalid},
          ((c >= RD_LAT) && ((c - RD_LAT) % 2 == 1)) ? 32'h1 : 32'h0);
      if ((c >= RD_LAT) && ((c - RD_LAT) % 2 == 0))
        chk($sformatf("rr c%0d s1_rdata", c), s1_if.readdata, 32'hDEADAAEF);
      if ((c >= RD_LAT) && ((c - RD_LAT) % 2 == 1))
        chk($sformatf("rr c%0d s2_rdata", c), s2_if.readdata, 32'h55AA55AA);
    end
    @(negedge clk);
    idle();

    // ---------------- clken freeze with a read in flight ----------------
    do_reset();
    s1_if.read = 1'b1; s1_if.address = 14'h21;
    #2;
    chk("frz accept s1_wait", {31'h0, s1_if.waitrequest}, 32'h0);
    @(posedge clk);
    #1;
    clken = 1'b0;
    s1_if.read = 1'b0;
    s2_if.read = 1'b1; s2_if.address = 14'h10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2;
      chk($sformatf("frz k%0d s1_wait", k), {31'h0, s1_if.waitrequest},   32'h1);
      chk($sformatf("frz k%0d s2_wait", k), {31'h0, s2_if.waitrequest},   32'h1);
      chk($sformatf("frz k%0d s1_rdv", k),  {31'h0, s1_if.readdatavalid}, 32'h0);
      chk($sformatf("frz k%0d s2_rdv", k),  {31'h0, s2_if.readdatavalid}, 32'h0);
    end
    @(negedge clk);
    clken = 1'b1;
    s2_if.read = 1'b0;
    for (int j = 0; j <= RD_LAT; j++) begin
      if (j != 0) @(negedge clk);
      #2;
      chk($sformatf("resume j%0d s1_rdv", j), {31'h0, s1_if.readdatavalid},
          (j == RD_LAT - 1) ? 32'h1 : 32'h0);
      chk($sformatf("resume j%0d s2_rdv", j), {31'h0, s2_if.readdatavalid}, 32'h0);
      if (j == RD_LAT - 1)
        chk("resume s1_rdata", s1_if.readdata, 32'h55AA55AA);
    end

    // ---------------- reset right after a read accept ----------------
    do_reset();
    s1_if.read = 1'b1; s1_if.address = 14'h10;
    s2_if.read = 1'b1; s2_if.address = 14'h21;
    #2;
    chk("rstrd s1_wait", {31'h0, s1_if.waitrequest}, 32'h0);
    chk("rstrd s2_wait", {31'h0, s2_if.waitrequest}, 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle();
    @(negedge clk);
    #2;
    chk("rstrd in_rst s1_rdv",   {31'h0, s1_if.readdatavalid}, 32'h0);
    chk("rstrd in_rst s1_rdata", s1_if.readdata, 32'h0);
    chk("rstrd in_rst s1_wait",  {31'h0, s1_if.waitrequest}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j <= RD_LAT; j++) begin
      if (j != 0) @(negedge clk);
      #2;
      chk($sformatf("rstrd j%0d s1_rdv", j), {31'h0, s1_if.readdatavalid}, 32'h0);
      chk($sformatf("rstrd j%0d s2_rdv", j), {31'h0, s2_if.readdatavalid}, 32'h0);
    end
    @(negedge clk);
    s1_if.read = 1'b1; s1_if.address = 14'h10;
    s2_if.read = 1'b1; s2_if.address = 14'h21;
    #2;
    chk("rstrd ptr s1_wait", {31'h0, s1_if.waitrequest}, 32'h0);
    chk("rstrd ptr s2_wait", {31'h0, s2_if.waitrequest}, 32'h1);
    @(negedge clk);
    idle();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
